// File: rtl/exec_writeback_unit.sv
// Execute/write-back stage that sits directly after the 64-bit x 32-entry register bank.
// It drives the bank read addresses and computes single-cycle ALU results. It also runs an
// iterative shift-add multiply. Results go back through the bank write port, and the last
// result is forwarded so that back-to-back dependent ops see fresh data.
module exec_writeback_unit #(
  parameter int unsigned XLEN      = 64,
  parameter int unsigned AW        = 5,
  parameter int unsigned MUL_STEPS = XLEN
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            issue_valid,
  output logic            issue_ready,
  input  logic [3:0]      op,
  input  logic [AW-1:0]   rs1,
  input  logic [AW-1:0]   rs2,
  input  logic [AW-1:0]   rd,
  output logic [AW-1:0]   a,
  output logic [AW-1:0]   b,
  input  logic [XLEN-1:0] aData,
  input  logic [XLEN-1:0] bData,
  output logic [AW-1:0]   c,
  output logic [XLEN-1:0] cData,
  output logic            write,
  output logic            busy
);

  localparam int unsigned SHW = $clog2(XLEN);
  localparam int unsigned SW  = $clog2(MUL_STEPS + 1);

  localparam logic [SW-1:0] LAST_STEP = SW'(MUL_STEPS - 1);

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] MUL  = 1'b1;

  localparam logic [3:0] OP_ADD  = 4'd0;
  localparam logic [3:0] OP_SUB  = 4'd1;
  localparam logic [3:0] OP_AND  = 4'd2;
  localparam logic [3:0] OP_OR   = 4'd3;
  localparam logic [3:0] OP_XOR  = 4'd4;
  localparam logic [3:0] OP_SLL  = 4'd5;
  localparam logic [3:0] OP_SRL  = 4'd6;
  localparam logic [3:0] OP_SRA  = 4'd7;
  localparam logic [3:0] OP_SLT  = 4'd8;
  localparam logic [3:0] OP_MUL  = 4'd9;

  logic [0:0]      state_q, state_d;
  logic [SW-1:0]   step_q, step_d;
  logic [XLEN-1:0] acc_q, acc_d;
  logic [XLEN-1:0] mcand_q, mcand_d;
  logic [XLEN-1:0] mplier_q, mplier_d;
  logic [AW-1:0]   mul_rd_q, mul_rd_d;
  logic            wb_valid_q, wb_valid_d;
  logic [AW-1:0]   wb_addr_q, wb_addr_d;
  logic [XLEN-1:0] wb_data_q, wb_data_d;

  logic            accept;
  logic [XLEN-1:0] opa, opb;
  logic [SHW-1:0]  shamt;
  logic [XLEN-1:0] alu_result;

  assign a           = rs1;
  assign b           = rs2;
  assign c           = wb_addr_q;
  assign cData       = wb_data_q;
  assign write       = wb_valid_q;
  assign issue_ready = (state_q == IDLE);
  assign busy        = (state_q == MUL);
  assign accept      = issue_valid && issue_ready;

  // The bank has not yet absorbed the result being written this cycle, so bypass it.
  assign opa   = (wb_valid_q && (wb_addr_q == rs1)) ? wb_data_q : aData;
  assign opb   = (wb_valid_q && (wb_addr_q == rs2)) ? wb_data_q : bData;
  assign shamt = opb[SHW-1:0];

  // Single-cycle ALU; reserved codes fall through to PASSA.
  always_comb begin
    alu_result = opa;
    case (op)
      OP_ADD:  alu_result = opa + opb;
      OP_SUB:  alu_result = opa - opb;
      OP_AND:  alu_result = opa & opb;
      OP_OR:   alu_result = opa | opb;
      OP_XOR:  alu_result = opa ^ opb;
      OP_SLL:  alu_result = opa << shamt;
      OP_SRL:  alu_result = opa >> shamt;
      OP_SRA:  alu_result = $unsigned($signed(opa) >>> shamt);
      OP_SLT:  alu_result = {{(XLEN-1){1'b0}}, ($signed(opa) < $signed(opb))};
      default: alu_result = opa;
    endcase
  end

  // Next-state: op acceptance, multiply iteration and write-back register load.
  always_comb begin
    state_d    = state_q;
    step_d     = step_q;
    acc_d      = acc_q;
    mcand_d    = mcand_q;
    mplier_d   = mplier_q;
    mul_rd_d   = mul_rd_q;
    wb_valid_d = 1'b0;
    wb_addr_d  = wb_addr_q;
    wb_data_d  = wb_data_q;

    case (state_q)
      IDLE: begin
        if (accept) begin
          if (op == OP_MUL) begin
            state_d  = MUL;
            step_d   = '0;
            acc_d    = '0;
            mcand_d  = opa;
            mplier_d = opb;
            mul_rd_d = rd;
          end else begin
            wb_valid_d = 1'b1;
            wb_addr_d  = rd;
            wb_data_d  = alu_result;
          end
        end
      end
      MUL: begin
        acc_d    = acc_q + (mplier_q[0] ? mcand_q : '0);
        mcand_d  = mcand_q << 1;
        mplier_d = mplier_q >> 1;
        step_d   = step_q + SW'(1);
        if (step_q == LAST_STEP) begin
          state_d    = IDLE;
          step_d     = '0;
          wb_valid_d = 1'b1;
          wb_addr_d  = mul_rd_q;
          wb_data_d  = acc_d;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State registers; reset drops any in-flight multiply without a write.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      step_q     <= '0;
      acc_q      <= '0;
      mcand_q    <= '0;
      mplier_q   <= '0;
      mul_rd_q   <= '0;
      wb_valid_q <= 1'b0;
      wb_addr_q  <= '0;
      wb_data_q  <= '0;
    end else begin
      state_q    <= state_d;
      step_q     <= step_d;
      acc_q      <= acc_d;
      mcand_q    <= mcand_d;
      mplier_q   <= mplier_d;
      mul_rd_q   <= mul_rd_d;
      wb_valid_q <= wb_valid_d;
      wb_addr_q  <= wb_addr_d;
      wb_data_q  <= wb_data_d;
    end
  end

endmodule

// File: tb/tb_exec_writeback_unit.sv
// Directed bench for exec_writeback_unit with a behavioural 32 x 64 register bank.
module tb_exec_writeback_unit;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        issue_valid = 1'b0;
  logic        issue_ready;
  logic [3:0]  op = 4'd0;
  logic [4:0]  rs1 = 5'd0, rs2 = 5'd0, rd = 5'd0;
  logic [4:0]  a, b, c;
  logic [63:0] aData, bData, cData;
  logic        write, busy;

  logic [63:0] bank [32];
  logic [63:0] snap [32];
  logic        pre_we = 1'b0;
  logic [4:0]  pre_addr = 5'd0;
  logic [63:0] pre_data = 64'd0;

  int n_vec = 0;
  int n_bad = 0;

  exec_writeback_unit dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .issue_valid (issue_valid),
    .issue_ready (issue_ready),
    .op          (op),
    .rs1         (rs1),
    .rs2         (rs2),
    .rd          (rd),
    .a           (a),
    .b           (b),
    .aData       (aData),
    .bData       (bData),
    .c           (c),
    .cData       (cData),
    .write       (write),
    .busy        (busy)
  );

  always #5 clk = ~clk;

  // Register bank: combinational read, write on rising edge; preload port has priority.
  assign aData = bank[a];
  assign bData = bank[b];
  always @(posedge clk) begin
    if (pre_we) bank[pre_addr] <= pre_data;
    else if (write) bank[c] <= cData;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish (got timeout, required completion)");
    $fatal(1);
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h required %h", name, act, exp);
    end
  endtask

  task automatic preload(input logic [4:0] addr, input logic [63:0] data);
    pre_we   = 1'b1;
    pre_addr = addr;
    pre_data = data;
    @(posedge clk);
    #1 pre_we = 1'b0;
  endtask

  task automatic issue(input logic [3:0] o, input logic [4:0] s1, input logic [4:0] s2,
                       input logic [4:0] d);
    op = o; rs1 = s1; rs2 = s2; rd = d;
    issue_valid = 1'b1;
    @(posedge clk);
    #1 issue_valid = 1'b0;
  endtask

  typedef struct {
    logic [3:0]  op;
    logic [4:0]  rd;
    logic [63:0] av;
    logic [63:0] bv;
    logic [63:0] exp;
  } vec_t;

  vec_t vecs [15];

  initial begin
    int k, busy_cnt, wr_cnt, mul_lat, add_lat, diff;
    logic acc_flag;
    logic [63:0] mul_data, add_data;

    vecs[0]  = '{4'd0,  5'd3,  64'd5, 64'd7, 64'd12};
    vecs[1]  = '{4'd1,  5'd4,  64'd0, 64'd1, 64'hFFFF_FFFF_FFFF_FFFF};
    vecs[2]  = '{4'd2,  5'd5,  64'hF0F0_F0F0_F0F0_F0F0, 64'hFF00_FF00_FF00_FF00,
                 64'hF000_F000_F000_F000};
    vecs[3]  = '{4'd3,  5'd6,  64'hF0F0_F0F0_F0F0_F0F0, 64'hFF00_FF00_FF00_FF00,
                 64'hFFF0_FFF0_FFF0_FFF0};
    vecs[4]  = '{4'd4,  5'd7,  64'hF0F0_F0F0_F0F0_F0F0, 64'hFF00_FF00_FF00_FF00,
                 64'h0FF0_0FF0_0FF0_0FF0};
    vecs[5]  = '{4'd5,  5'd8,  64'd1, 64'd68, 64'h10};
    vecs[6]  = '{4'd6,  5'd9,  64'h8000_0000_0000_0000, 64'd4, 64'h0800_0000_0000_0000};
    vecs[7]  = '{4'd7,  5'd10, 64'h8000_0000_0000_0000, 64'd4, 64'hF800_0000_0000_0000};
    vecs[8]  = '{4'd7,  5'd11, 64'hFFFF_FFFF_FFFF_FFFF, 64'd4, 64'hFFFF_FFFF_FFFF_FFFF};
    vecs[9]  = '{4'd8,  5'd12, 64'hFFFF_FFFF_FFFF_FFFF, 64'd0, 64'd1};
    vecs[10] = '{4'd8,  5'd13, 64'd5, 64'hFFFF_FFFF_FFFF_FFFF, 64'd0};
    vecs[11] = '{4'd10, 5'd14, 64'hDEAD_BEEF_0123_4567, 64'd1, 64'hDEAD_BEEF_0123_4567};
    vecs[12] = '{4'd13, 5'd15, 64'h0123_4567_89AB_CDEF, 64'd5, 64'h0123_4567_89AB_CDEF};
    vecs[13] = '{4'd0,  5'd0,  64'hFFFF_FFFF_FFFF_FFFF, 64'd2, 64'd1};
    vecs[14] = '{4'd5,  5'd16, 64'd3, 64'd63, 64'h8000_0000_0000_0000};

    // Reset values
    repeat (2) @(posedge clk);
    #1;
    check("reset_write", {63'd0, write}, 64'd0);
    check("reset_c", {59'd0, c}, 64'd0);
    check("reset_cdata", cData, 64'd0);
    check("reset_busy", {63'd0, busy}, 64'd0);
    check("reset_ready", {63'd0, issue_ready}, 64'd1);
    rs1 = 5'd7; rs2 = 5'd19;
    #1;
    check("read_addr_a", {59'd0, a}, 64'd7);
    check("read_addr_b", {59'd0, b}, 64'd19);
    @(posedge clk);
    #1 rst_n = 1'b1;

    // Table of single-cycle ops
    for (int i = 0; i < 15; i++) begin
      preload(5'd1, vecs[i].av);
      preload(5'd2, vecs[i].bv);
      issue(vecs[i].op, 5'd1, 5'd2, vecs[i].rd);
      @(negedge clk);
      check($sformatf("vec%0d_write", i), {63'd0, write}, 64'd1);
      check($sformatf("vec%0d_c", i), {59'd0, c}, {59'd0, vecs[i].rd});
      check($sformatf("vec%0d_cdata", i), cData, vecs[i].exp);
      @(negedge clk);
      check($sformatf("vec%0d_write_drop", i), {63'd0, write}, 64'd0);
      @(posedge clk);
      #1;
    end

    // Dependent chain SUB -> SRA -> SLT, back to back
    preload(5'd1, 64'd0);
    preload(5'd2, 64'd1);
    preload(5'd10, 64'd4);
    op = 4'd1; rs1 = 5'd1; rs2 = 5'd2; rd = 5'd4; issue_valid = 1'b1;
    @(posedge clk);
    #1 op = 4'd7; rs1 = 5'd4; rs2 = 5'd10; rd = 5'd5;
    check("chain_sub_c", {59'd0, c}, 64'd4);
    check("chain_sub_cdata", cData, 64'hFFFF_FFFF_FFFF_FFFF);
    @(posedge clk);
    #1 op = 4'd8; rs1 = 5'd4; rs2 = 5'd1; rd = 5'd6;
    check("chain_sra_write", {63'd0, write}, 64'd1);
    check("chain_sra_c", {59'd0, c}, 64'd5);
    check("chain_sra_cdata", cData, 64'hFFFF_FFFF_FFFF_FFFF);
    @(posedge clk);
    #1 issue_valid = 1'b0;
    check("chain_slt_write", {63'd0, write}, 64'd1);
    check("chain_slt_c", {59'd0, c}, 64'd6);
    check("chain_slt_cdata", cData, 64'd1);
    @(posedge clk);
    #1;

    // Back-to-back ADD with forwarding; r3 cleared so a stale read cannot match
    preload(5'd1, 64'd5);
    preload(5'd2, 64'd7);
    preload(5'd3, 64'd0);
    op = 4'd0; rs1 = 5'd1; rs2 = 5'd2; rd = 5'd3; issue_valid = 1'b1;
    @(posedge clk);
    #1 rs1 = 5'd3; rs2 = 5'd3; rd = 5'd8;
    check("fwd_first_cdata", cData, 64'd12);
    @(posedge clk);
    #1 issue_valid = 1'b0;
    check("fwd_second_c", {59'd0, c}, 64'd8);
    check("fwd_second_cdata", cData, 64'd24);
    @(posedge clk);
    #1;

    // ADD then MUL back to back; an ADD is held on issue_valid during the multiply
    preload(5'd1, 64'h0000_0001_0000_0000);
    preload(5'd2, 64'h0000_0003_0000_0001);
    op = 4'd0; rs1 = 5'd1; rs2 = 5'd2; rd = 5'd12; issue_valid = 1'b1;
    @(posedge clk);
    #1 op = 4'd9; rd = 5'd9;
    check("pre_mul_write", {63'd0, write}, 64'd1);
    check("pre_mul_cdata", cData, 64'h0000_0004_0000_0001);
    @(posedge clk);
    #1 op = 4'd0; rs1 = 5'd9; rs2 = 5'd9; rd = 5'd11;
    busy_cnt = 0; wr_cnt = 0; mul_lat = 0; add_lat = 0; acc_flag = 1'b0;
    mul_data = '0; add_data = '0;
    for (k = 1; k <= 100; k++) begin
      @(negedge clk);
      if (busy) busy_cnt++;
      if (write) wr_cnt++;
      if (write && c == 5'd9 && mul_lat == 0) begin mul_lat = k; mul_data = cData; end
      if (write && c == 5'd11 && add_lat == 0) begin add_lat = k; add_data = cData; end
      if (acc_flag) issue_valid = 1'b0;
      if (issue_ready && issue_valid) acc_flag = 1'b1;
    end
    issue_valid = 1'b0;
    check("mul_busy_cycles", 64'(busy_cnt), 64'd64);
    check("mul_latency", 64'(mul_lat), 64'd65);
    check("mul_cdata", mul_data, 64'h0000_0001_0000_0000);
    check("held_add_latency", 64'(add_lat), 64'd66);
    check("held_add_cdata", add_data, 64'h0000_0002_0000_0000);
    check("mul_write_count", 64'(wr_cnt), 64'd2);
    check("mul_bank_r9", bank[9], 64'h0000_0001_0000_0000);
    @(posedge clk);
    #1;

    // Reset in the middle of a multiply
    preload(5'd1, 64'd3);
    preload(5'd2, 64'd5);
    for (int i = 0; i < 32; i++) snap[i] = bank[i];
    issue(4'd9, 5'd1, 5'd2, 5'd13);
    repeat (30) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("midrst_busy", {63'd0, busy}, 64'd0);
    check("midrst_ready", {63'd0, issue_ready}, 64'd1);
    check("midrst_write", {63'd0, write}, 64'd0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    wr_cnt = 0;
    repeat (80) begin
      @(negedge clk);
      if (write) wr_cnt++;
    end
    check("midrst_no_write", 64'(wr_cnt), 64'd0);
    diff = 0;
    for (int i = 0; i < 32; i++) if (bank[i] !== snap[i]) diff++;
    check("midrst_bank_unchanged", 64'(diff), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
